instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//   Producer-side counterpart of the CPU instruction decoder: accepts symbolic
//   instruction requests (kind + register/immediate fields) over valid/ready,
//   packs them into 32-bit MIPS-format words, buffers them in a FIFO, and
//   writes them sequentially into instruction memory for the single-cycle CPU.
//   Used by the boot loader / test harness to fill program memory.
// PARAMETERS
//   DEPTH      4      FIFO entries (power of two, >=2)
//   ADDR_W     10     byte-address width of instruction memory port
//   BASE_ADDR  0      byte address of first written word (word-aligned)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active high
//   in_valid   in   1      request valid
//   in_ready   out  1      request accepted when in_valid & in_ready
//   in_kind    in   4      0 add,1 sub,2 and,3 or,4 slt,5 addi,6 andi,7 ori,8 slti,9 sw,10 lw,11 j; 12-15 illegal
//   in_rs      in   5      rs field
//   in_rt      in   5      rt field (destination for I-type, data reg for sw/lw)
//   in_rd      in   5      rd field (R-type only)
//   in_imm     in   16     immediate (I-type)
//   in_target  in   26     jump target (j only)
//   restart    in   1      sync: clear FIFO, reload mem_addr to BASE_ADDR, clear count
//   mem_we     out  1      write strobe; holds until mem_ready
//   mem_ready  in   1      memory accepts write when mem_we & mem_ready
//   mem_addr   out  ADDR_W byte address of current write
//   mem_wdata  out  32     encoded instruction word
//   word_count out  16     words written since reset/restart (saturates at 0xFFFF)
//   err_illegal out 1      one-cycle pulse for an accepted illegal kind
// BEHAVIOUR
//   Reset: FIFO empty, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0,
//     err_illegal=0; in_ready=1 in the first cycle after reset.
//   Encoding: R-type {6'b000000,rs,rt,rd,5'b0,funct}; funct add 100000, sub 100010,
//     and 100100, or 100101, slt 101010. I-type {op,rs,rt,imm}; op addi 001000,
//     andi 001100, ori 001101, slti 001010, sw 101011, lw 100011.
//     J-type {6'b000010,target}. Unused input fields ignored.
//   Accept: in_ready = !full (registered occupancy; a same-cycle pop does NOT
//     raise in_ready when full). Encoded word pushed on the accepting edge.
//   Illegal kind: handshake completes, nothing pushed, err_illegal=1 next cycle.
//   Latency: request accepted in cycle N -> mem_we=1 with its word in cycle N+1
//     earliest (FIFO was empty, no restart).
//   Write port: mem_we = !empty; mem_wdata/mem_addr = FIFO head / address counter,
//     stable while mem_we & !mem_ready. On mem_we & mem_ready: pop, mem_addr += 4
//     (wraps modulo 2^ADDR_W), word_count += 1 (saturating).
//   Simultaneous push and pop when not full: occupancy unchanged, order preserved.
//   restart has priority over push/pop that cycle; word in flight is dropped,
//     err_illegal cleared. rst has priority over restart. mem_wdata=0 when empty.
// TESTING
//   add rs=1 rt=2 rd=3, mem_ready=1 -> next cycle mem_we=1, addr 0x000, wdata 0x00221820.
//   addi rs=1 rt=2 imm=5; lw rs=29 rt=4 imm=0x10; j target=0x40 back-to-back ->
//     0x20220005@0x000, 0x8FA40010@0x004, 0x08000040@0x008, word_count=3.
//   mem_ready=0, push 5 requests (DEPTH=4) -> in_ready=0 after 4th, 5th held;
//     mem_ready=1 -> all 5 written in order, addresses 0x000..0x010.
//   in_kind=13 -> handshake done, err_illegal pulse, no mem_we, word_count unchanged.
//   ADDR_W=4, write 5 words -> addresses 0x0,0x4,0x8,0xC,0x0 (wrap).
//   restart with 3 words queued, mem_ready=0 -> next cycle mem_we=0, mem_addr=BASE_ADDR,
//     word_count=0; rst mid-stream gives same state.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instruction requests into 32-bit MIPS words,
// buffers them in a small FIFO and writes them sequentially into instruction
// memory.
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  request handshake; in_kind selects the instruction
//   in_rs/rt/rd/imm/target  instruction fields (unused fields ignored)
//   restart            clears FIFO, address counter and word count
//   mem_we/mem_ready   memory write handshake; mem_addr/mem_wdata payload
//   word_count         words written since reset/restart (saturating)
//   err_illegal        one-cycle pulse after an accepted illegal kind
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              restart,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       word_count,
    output logic              err_illegal
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wc_q, wc_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        push;
    logic        pop;

    // Instruction field packing
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        unique case (in_kind)
            4'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
            4'd1:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
            4'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
            4'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
            4'd4:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
            4'd5:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
            4'd6:  enc_word = {6'b001100, in_rs, in_rt, in_imm};
            4'd7:  enc_word = {6'b001101, in_rs, in_rt, in_imm};
            4'd8:  enc_word = {6'b001010, in_rs, in_rt, in_imm};
            4'd9:  enc_word = {6'b101011, in_rs, in_rt, in_imm};
            4'd10: enc_word = {6'b100011, in_rs, in_rt, in_imm};
            4'd11: enc_word = {6'b000010, in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    // in_ready reflects registered occupancy only; a pop while full does not free a slot this cycle
    assign in_ready    = (cnt_q != CNT_W'(DEPTH));
    assign mem_we      = (cnt_q != '0);
    assign mem_wdata   = mem_we ? fifo_q[rd_ptr_q] : 32'h0;
    assign mem_addr    = addr_q;
    assign word_count  = wc_q;
    assign err_illegal = err_q;

    assign accept = in_valid & in_ready;
    assign push   = accept & enc_legal & ~restart;
    assign pop    = mem_we & mem_ready & ~restart;

    // Next-state for pointers, occupancy, address and counters
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wc_d     = wc_q;
        err_d    = 1'b0;
        if (restart) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            addr_d   = ADDR_W'(BASE_ADDR);
            wc_d     = 16'h0;
        end else begin
            err_d = accept & ~enc_legal;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                addr_d   = addr_q + ADDR_W'(4);
                if (wc_q != 16'hFFFF) begin
                    wc_d = wc_q + 16'd1;
                end
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            addr_q   <= ADDR_W'(BASE_ADDR);
            wc_q     <= 16'h0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wc_q     <= wc_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage needs no reset; empty entries are masked at the output
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations for the documented examples.
// Two instances share stimulus: ADDR_W=10 and ADDR_W=4 (address wrap).
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int FUNCT [5] = '{32, 34, 36, 37, 42};
    localparam int OPC   [6] = '{8, 12, 13, 10, 43, 35};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_kind = 4'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;
    logic        restart = 1'b0;
    logic        mem_ready = 1'b0;

    logic        a_in_ready, a_mem_we, a_err;
    logic [9:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [15:0] a_wc;
    logic        b_in_ready, b_mem_we, b_err;
    logic [3:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [15:0] b_wc;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] mq [$];
    int          m_written = 0;
    int          m_wc = 0;
    bit          m_err = 1'b0;

    // Logs of observed memory writes
    logic [31:0] la_addr [$];
    logic [31:0] la_data [$];
    logic [31:0] lb_addr [$];

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(10), .BASE_ADDR(0)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .restart(restart),
        .mem_we(a_mem_we), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .word_count(a_wc), .err_illegal(a_err)
    );

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .restart(restart),
        .mem_we(b_mem_we), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .word_count(b_wc), .err_illegal(b_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction word from the MIPS field layout
    function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [15:0] imm, input logic [25:0] tgt);
        int kk;
        kk = int'(k);
        if (kk < 5)
            return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(FUNCT[kk]);
        if (kk < 11)
            return (32'(OPC[kk - 5]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        return (32'd2 << 26) | 32'(tgt);
    endfunction

    // One cycle: compare at negedge, advance the model, then let the DUT clock
    task automatic step();
        bit fire;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        @(negedge clk);
        exp_data = (mq.size() > 0) ? mq[0] : 32'h0;
        exp_addr = 32'(4 * m_written);
        chk("a_in_ready", 32'(a_in_ready), 32'(mq.size() < DEPTH));
        chk("a_mem_we",   32'(a_mem_we),   32'(mq.size() > 0));
        chk("a_wdata",    a_mem_wdata,     exp_data);
        chk("a_addr",     32'(a_mem_addr), exp_addr & 32'h3FF);
        chk("a_wc",       32'(a_wc),       32'(m_wc));
        chk("a_err",      32'(a_err),      32'(m_err));
        chk("b_mem_we",   32'(b_mem_we),   32'(mq.size() > 0));
        chk("b_wdata",    b_mem_wdata,     exp_data);
        chk("b_addr",     32'(b_mem_addr), exp_addr & 32'hF);
        chk("b_err",      32'(b_err),      32'(m_err));
        if (!rst && !restart && mem_ready) begin
            if (a_mem_we) begin
                la_addr.push_back(32'(a_mem_addr));
                la_data.push_back(a_mem_wdata);
            end
            if (b_mem_we) lb_addr.push_back(32'(b_mem_addr));
        end
        if (rst || restart) begin
            mq.delete();
            m_written = 0;
            m_wc = 0;
            m_err = 1'b0;
        end else begin
            fire = in_valid && (mq.size() < DEPTH);
            if (mq.size() > 0 && mem_ready) begin
                void'(mq.pop_front());
                m_written++;
                if (m_wc < 65535) m_wc++;
            end
            m_err = fire && (in_kind > 4'd11);
            if (fire && in_kind <= 4'd11)
                mq.push_back(enc(in_kind, in_rs, in_rt, in_rd, in_imm, in_target));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_valid  = 1'b1;
        in_kind   = k;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
    endtask

    task automatic clear_logs();
        la_addr.delete();
        la_data.delete();
        lb_addr.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_mem_we",   32'(a_mem_we),   32'd0);

        // Single add: word visible the cycle after acceptance
        mem_ready = 1'b1;
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        step();
        in_valid = 1'b0;
        chk("t1_we_next", 32'(a_mem_we), 32'd1);
        chk("t1_data_next", a_mem_wdata, 32'h00221820);
        repeat (3) step();
        chk("t1_nwr", 32'(la_addr.size()), 32'd1);
        chk("t1_addr", la_addr[0], 32'h000);
        chk("t1_data", la_data[0], 32'h00221820);

        // Back-to-back addi, lw, j after a restart
        restart = 1'b1;
        step();
        restart = 1'b0;
        clear_logs();
        set_req(4'd5, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0);
        step();
        set_req(4'd10, 5'd29, 5'd4, 5'd0, 16'h0010, 26'd0);
        step();
        set_req(4'd11, 5'd0, 5'd0, 5'd0, 16'd0, 26'h40);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("t2_nwr", 32'(la_addr.size()), 32'd3);
        chk("t2_d0", la_data[0], 32'h20220005);
        chk("t2_d1", la_data[1], 32'h8FA40010);
        chk("t2_d2", la_data[2], 32'h08000040);
        chk("t2_a2", la_addr[2], 32'h008);
        chk("t2_wc", 32'(a_wc), 32'd3);

        // Fill the FIFO with memory stalled, fifth request must wait
        restart = 1'b1;
        step();
        restart = 1'b0;
        clear_logs();
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_req(4'd5, 5'd1, 5'(i), 5'd0, 16'(i), 26'd0);
            step();
        end
        chk("t3_full", 32'(a_in_ready), 32'd0);
        set_req(4'd5, 5'd1, 5'd5, 5'd0, 16'd5, 26'd0);
        repeat (2) step();
        chk("t3_held", 32'(a_in_ready), 32'd0);
        mem_ready = 1'b1;
        repeat (2) step();
        in_valid = 1'b0;
        repeat (8) step();
        chk("t3_nwr", 32'(la_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t3_addr", la_addr[i], 32'(4 * i));
            chk("t3_data", la_data[i], 32'h20200000 | (32'(i + 1) << 16) | 32'(i + 1));
        end
        chk("t3_wrap_nwr", 32'(lb_addr.size()), 32'd5);
        chk("t3_wrap_a3", lb_addr[3], 32'hC);
        chk("t3_wrap_a4", lb_addr[4], 32'h0);

        // Illegal kind: handshake completes, error pulse, nothing written
        clear_logs();
        set_req(4'd13, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
        step();
        in_valid = 1'b0;
        chk("t4_err", 32'(a_err), 32'd1);
        chk("t4_we", 32'(a_mem_we), 32'd0);
        step();
        chk("t4_err_clr", 32'(a_err), 32'd0);
        chk("t4_wc", 32'(a_wc), 32'd5);
        chk("t4_nwr", 32'(la_addr.size()), 32'd0);

        // Restart with three words queued
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(4'd7, 5'(i), 5'd9, 5'd0, 16'hBEEF, 26'd0);
            step();
        end
        in_valid = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("t5_we", 32'(a_mem_we), 32'd0);
        chk("t5_addr", 32'(a_mem_addr), 32'd0);
        chk("t5_wc", 32'(a_wc), 32'd0);
        step();

        // Reset mid-stream
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(4'd1, 5'(i), 5'd2, 5'd3, 16'd0, 26'd0);
            step();
        end
        mem_ready = 1'b0;
        set_req(4'd2, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_we", 32'(a_mem_we), 32'd0);
        chk("t6_addr", 32'(a_mem_addr), 32'd0);
        chk("t6_wc", 32'(a_wc), 32'd0);
        chk("t6_ready", 32'(a_in_ready), 32'd1);
        step();

        // Every kind, with memory back-pressure alternating
        for (int k = 0; k < 16; k++) begin
            set_req(4'(k), 5'(k + 1), 5'((k * 3) & 31), 5'(k ^ 5), 16'h1234 + 16'(k),
                    26'h123456 + 26'(k));
            mem_ready = (k % 2 == 1);
            step();
        end
        in_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (10) step();
        chk("end_drained", 32'(a_mem_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
